// File: rtl/alu_result_display.sv
// alu_result_display: shows the 8-bit ALU result on three active-low
// seven-segment digits.
// Each change of `result` is converted to BCD by a sequential double-dabble
// engine (one shift-and-add-3 step per cycle). The display digits are then
// reloaded, with optional leading-zero blanking.
//
// Parameters:
//   BLANK_LZ  1 = blank leading zero digits (units never blanked), 0 = show all
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   result  unsigned ALU result, sampled only while idle
//   hex0    units digit, active-low {g,f,e,d,c,b,a}
//   hex1    tens digit, same encoding
//   hex2    hundreds digit, same encoding
//   bcd     displayed value {hundreds, tens, units}
//   busy    high while a conversion is in flight
module alu_result_display #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [11:0] bcd,
  output logic       busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DIGITS = 3;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  // Upper digits come out of reset showing what a zero value should look like
  localparam logic [SEG_W-1:0] HEX_HI_RST = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_UPDATE  = 2'd2
  } state_e;

  state_e             state_q,   state_d;
  logic [DATA_W-1:0]  last_q,    last_d;
  logic [DATA_W-1:0]  shift_q,   shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic [BCD_W-1:0]   bcd_q,     bcd_d;
  logic [SEG_W-1:0]   hex0_q,    hex0_d;
  logic [SEG_W-1:0]   hex1_q,    hex1_d;
  logic [SEG_W-1:0]   hex2_q,    hex2_d;
  logic               busy_q,    busy_d;

  logic [BCD_W-1:0]   adj;
  logic [3:0]         dig_h, dig_t, dig_u;

  // BCD digit to active-low gfedcba; non-decimal codes show blank
  function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction of every scratch nibble before the shift
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
  end

  assign dig_h = scratch_q[11:8];
  assign dig_t = scratch_q[7:4];
  assign dig_u = scratch_q[3:0];

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    bcd_d     = bcd_q;
    hex0_d    = hex0_q;
    hex1_d    = hex1_q;
    hex2_d    = hex2_q;

    case (state_q)
      S_IDLE: begin
        if (result != last_q) begin
          last_d    = result;
          shift_d   = result;
          scratch_d = '0;
          count_d   = '0;
          state_d   = S_CONVERT;
        end
      end
      S_CONVERT: begin
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_ITER) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        bcd_d  = scratch_q;
        hex0_d = seg_encode(dig_u);
        hex1_d = (BLANK_LZ && dig_h == 4'd0 && dig_t == 4'd0) ? SEG_BLANK : seg_encode(dig_t);
        hex2_d = (BLANK_LZ && dig_h == 4'd0) ? SEG_BLANK : seg_encode(dig_h);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      bcd_q     <= '0;
      hex0_q    <= SEG_ZERO;
      hex1_q    <= HEX_HI_RST;
      hex2_q    <= HEX_HI_RST;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      bcd_q     <= bcd_d;
      hex0_q    <= hex0_d;
      hex1_q    <= hex1_d;
      hex2_q    <= hex2_d;
      busy_q    <= busy_d;
    end
  end

  assign hex0 = hex0_q;
  assign hex1 = hex1_q;
  assign hex2 = hex2_q;
  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Bench for alu_result_display: two instances (blanking on and off) share
// the stimulus. A timer-based model tracks the displayed value, and every
// falling edge compares all outputs against it. Directed literal checks pin
// the worked examples, followed by randomized result changes and resets.
module tb_alu_result_display;

  logic       clk;
  logic       rst;
  logic [7:0] result;
  logic [6:0] hex0_b, hex1_b, hex2_b, hex0_n, hex1_n, hex2_n;
  logic [11:0] bcd_b, bcd_n;
  logic       busy_b, busy_n;

  int n_cmp = 0;
  int n_err = 0;

  // Model: conversion timer, last captured value, displayed value
  int  m_cnt   = 0;
  int  m_last  = 0;
  int  m_disp  = 0;
  bit  m_valid = 0;

  alu_result_display #(.BLANK_LZ(1'b1)) u_blank (
    .clk(clk), .rst(rst), .result(result),
    .hex0(hex0_b), .hex1(hex1_b), .hex2(hex2_b),
    .bcd(bcd_b), .busy(busy_b)
  );

  alu_result_display #(.BLANK_LZ(1'b0)) u_noblank (
    .clk(clk), .rst(rst), .result(result),
    .hex0(hex0_n), .hex1(hex1_n), .hex2(hex2_n),
    .bcd(bcd_n), .busy(busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [11:0] bcd_of(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Expected segments for digit position pos (0 units, 1 tens, 2 hundreds)
  function automatic logic [6:0] hex_of(input int v, input int pos, input bit blank);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    if (pos == 0) return seg_of(u);
    if (pos == 1) return (blank && v < 10) ? 7'b1111111 : seg_of(t);
    return (blank && h == 0) ? 7'b1111111 : seg_of(h);
  endfunction

  // Model update: capture when idle and changed, display after 10 edges
  always @(posedge clk) begin
    if (rst) begin
      m_cnt   = 0;
      m_last  = 0;
      m_disp  = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_cnt == 0) begin
        if (int'(result) != m_last) begin
          m_last = int'(result);
          m_cnt  = 9;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) m_disp = m_last;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy_b", 12'(busy_b), 12'(m_cnt != 0));
      check("busy_n", 12'(busy_n), 12'(m_cnt != 0));
      check("bcd_b",  bcd_b, bcd_of(m_disp));
      check("bcd_n",  bcd_n, bcd_of(m_disp));
      check("hex0_b", 12'(hex0_b), 12'(hex_of(m_disp, 0, 1'b1)));
      check("hex1_b", 12'(hex1_b), 12'(hex_of(m_disp, 1, 1'b1)));
      check("hex2_b", 12'(hex2_b), 12'(hex_of(m_disp, 2, 1'b1)));
      check("hex0_n", 12'(hex0_n), 12'(hex_of(m_disp, 0, 1'b0)));
      check("hex1_n", 12'(hex1_n), 12'(hex_of(m_disp, 1, 1'b0)));
      check("hex2_n", 12'(hex2_n), 12'(hex_of(m_disp, 2, 1'b0)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_digits(input string tag, input logic [6:0] h2, input logic [6:0] h1,
                              input logic [6:0] h0);
    check({tag, "_hex2"}, 12'(hex2_b), 12'(h2));
    check({tag, "_hex1"}, 12'(hex1_b), 12'(h1));
    check({tag, "_hex0"}, 12'(hex0_b), 12'(h0));
  endtask

  // Drive v before E0 and step to just after E9
  task automatic convert(input logic [7:0] v);
    result = v;
    step(10);
  endtask

  int hold;

  initial begin
    rst    = 1'b1;
    result = 8'd0;
    step(2);
    rst = 1'b0;
    step(20);
    check("lit_rst_bcd", bcd_b, 12'h000);
    check("lit_rst_busy", 12'(busy_b), 12'h0);
    check_digits("lit_rst", 7'b1111111, 7'b1111111, 7'b1000000);
    check("lit_rst_n_hex2", 12'(hex2_n), 12'(7'b1000000));

    // 123: busy through E8, display after E9
    result = 8'd123;
    step(1);
    check("lit_123_busy_e0", 12'(busy_b), 12'h1);
    step(8);
    check("lit_123_busy_e8", 12'(busy_b), 12'h1);
    check("lit_123_bcd_old", bcd_b, 12'h000);
    step(1);
    check("lit_123_busy_e9", 12'(busy_b), 12'h0);
    check("lit_123_bcd", bcd_b, 12'h123);
    check_digits("lit_123", 7'b1111001, 7'b0100100, 7'b0110000);

    convert(8'd255);
    check("lit_255_bcd", bcd_b, 12'h255);
    check_digits("lit_255", 7'b0100100, 7'b0010010, 7'b0010010);

    convert(8'd7);
    check_digits("lit_7", 7'b1111111, 7'b1111111, 7'b1111000);
    check("lit_7_n_hex2", 12'(hex2_n), 12'(7'b1000000));
    check("lit_7_n_hex1", 12'(hex1_n), 12'(7'b1000000));

    convert(8'd105);
    check("lit_105_hex1", 12'(hex1_b), 12'(7'b1000000));
    check("lit_105_bcd", bcd_b, 12'h105);

    // 50 then 60 at E3: 50 shown after E9, 60 after E19
    result = 8'd50;
    step(3);
    result = 8'd60;
    step(7);
    check("lit_50_bcd", bcd_b, 12'h050);
    step(1);
    check("lit_60_busy_e10", 12'(busy_b), 12'h1);
    step(9);
    check("lit_60_bcd", bcd_b, 12'h060);

    // 200 with reset at E4
    result = 8'd200;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("lit_rst4_busy", 12'(busy_b), 12'h0);
    check("lit_rst4_bcd", bcd_b, 12'h000);
    check_digits("lit_rst4", 7'b1111111, 7'b1111111, 7'b1000000);
    step(1);
    check("lit_200_busy", 12'(busy_b), 12'h1);
    step(9);
    check("lit_200_bcd", bcd_b, 12'h200);
    check_digits("lit_200", 7'b0100100, 7'b1000000, 7'b1000000);

    // Randomized result changes, hold times and occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) != 0) result = 8'($urandom_range(0, 255));
      hold = $urandom_range(1, 14);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 2));
        rst = 1'b0;
      end
      step(hold);
    end
    step(12);
    check("rand_final_bcd", bcd_b, bcd_of(int'(result)));
    check("rand_final_busy", 12'(busy_b), 12'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
